axi_traffic_gen: RTL and testbench
==================================

AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 Parameter MST_ID, default 0: ID value driven on AWID and ARID, and expected on BID and RID.
REQ-002 Parameter WIDTH_ID, default 4: ID width in bits.
REQ-003 Parameter WIDTH_AD, default 32: address width.
REQ-004 Parameter WIDTH_DA, default 32: data width (8..1024, power of 2); WIDTH_DS=WIDTH_DA/8; beat size SZ=clogb2(WIDTH_DS).
REQ-005 Parameter NUM_BURST, default 4: write/read-compare bursts per run (1..65535).
REQ-006 Port ACLK, input, 1: the single clock; all logic is on the rising edge.
REQ-007 Port ARESET, input, 1: synchronous, active-high reset.
REQ-008 Port START, input, 1: run request, sampled only in IDLE.
REQ-009 Port START_ADDR, input, WIDTH_AD: address of the first burst.
REQ-010 Port BURST_LEN, input, 4: AXI3 AxLEN value; beats per burst N=BURST_LEN+1.
REQ-011 Port SEED, input, WIDTH_DA: data pattern base.
REQ-012 Port BUSY, output, 1: a run is in progress.
REQ-013 Port DONE, output, 1: one-cycle pulse at run end.
REQ-014 Port CFG_ERR, output, 1: one-cycle pulse when START is rejected.
REQ-015 Port ERR_CNT, output, 16: saturating error count for the current run.
REQ-016 Ports AWID/AWADDR/AWLEN[3:0]/AWSIZE[2:0]/AWBURST[1:0]/AWVALID are outputs and AWREADY is an input: the AXI3 write-address channel.
REQ-017 Ports WID/WDATA/WSTRB/WLAST/WVALID are outputs and WREADY is an input: the AXI3 write-data channel.
REQ-018 Ports BID/BRESP/BVALID are inputs and BREADY is an output: the AXI3 write-response channel.
REQ-019 Ports ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID are outputs and ARREADY is an input: the AXI3 read-address channel.
REQ-020 Ports RID/RDATA/RRESP/RLAST/RVALID are inputs and RREADY is an output: the AXI3 read-data channel.

Function
REQ-021 FSM states SHALL be IDLE, AW, W, B, AR, R, NEXT, with one outstanding transaction at a time.
REQ-022 IDLE->AW SHALL occur on START=1 when START_ADDR is aligned to N*WIDTH_DS bytes and N*WIDTH_DS<=4096.
REQ-023 START in IDLE with a misaligned or oversize configuration SHALL pulse CFG_ERR for one cycle and leave the FSM in IDLE.
REQ-024 START_ADDR, BURST_LEN and SEED SHALL be latched on the accepted START; BUSY and AWVALID SHALL both be 1 on the next cycle, and ERR_CNT SHALL clear to 0 on the same edge.
REQ-025 START while BUSY=1 SHALL be ignored.
REQ-026 Every VALID SHALL be held until its READY handshake, with payload stable while VALID=1 and READY=0.
REQ-027 AW->W SHALL occur on the AW handshake; WVALID SHALL rise no earlier than the cycle after the AW handshake.
REQ-028 In W, N beats SHALL be sent; WLAST=1 only on beat N-1; WSTRB all ones; WID=MST_ID.
REQ-029 W->B SHALL occur after the WLAST handshake; BREADY=1 only in B.
REQ-030 B->AR SHALL occur on the B handshake, with ARADDR equal to this burst's AWADDR.
REQ-031 AR->R SHALL occur on the AR handshake; RREADY=1 only in R.
REQ-032 R->NEXT SHALL occur on the handshake of the N-th R beat.
REQ-033 From NEXT, the FSM SHALL go to AW if bursts remain, else to IDLE with a one-cycle DONE pulse and BUSY=0 on that same cycle.
REQ-034 AxSIZE SHALL equal SZ, AxBURST SHALL be 2'b01 (INCR), and AxLEN SHALL equal the latched BURST_LEN.
REQ-035 The address of burst n SHALL be START_ADDR+n*N*WIDTH_DS, mod 2^WIDTH_AD.
REQ-036 The data of beat k in burst n SHALL be SEED+n*N+k, mod 2^WIDTH_DA.
REQ-037 Each beat SHALL increment ERR_CNT by at most 1 when any of: BRESP!=0, BID!=MST_ID, RRESP!=0, RID!=MST_ID, RDATA!=expected, or RLAST!=(k==N-1).
REQ-038 ERR_CNT SHALL saturate at 16'hFFFF.
REQ-039 ERR_CNT SHALL hold its value after DONE until the next accepted START.
REQ-040 An early RLAST SHALL NOT end the burst; the FSM SHALL end R only on the beat count.

Reset
REQ-041 ARESET=1 at a rising edge SHALL force IDLE and drive all VALIDs, BREADY, RREADY, WLAST, BUSY, DONE and CFG_ERR to 0, ERR_CNT to 0, and AxADDR and WDATA to 0.
REQ-042 ARESET mid-run SHALL abort on the next edge with no DONE pulse; a START is accepted on the first cycle after ARESET is released.

Verification
REQ-043 Scenario: WIDTH_DA=32, NUM_BURST=2, START_ADDR=0x100, BURST_LEN=3, SEED=0xA0, zero-wait memory -> AWADDR 0x100 then 0x110; WDATA A0..A3 then A4..A7; DONE pulses once; ERR_CNT=0.
REQ-044 Scenario: random READY/VALID stalls of 0-5 cycles -> same data as REQ-043, payload stable during stalls, ERR_CNT=0.
REQ-045 Scenario: memory corrupts RDATA on one beat and returns BRESP=2'b10 once -> ERR_CNT=2.
REQ-046 Scenario: START_ADDR=0x104 with BURST_LEN=3 -> CFG_ERR pulses, BUSY stays 0, AWVALID stays 0.
REQ-047 Scenario: ARESET asserted during W beat 2 -> all VALIDs 0 on the next cycle; a new START then runs to completion with ERR_CNT=0.
REQ-048 Scenario: START_ADDR=0xFFFFFFF0, BURST_LEN=3, NUM_BURST=2 -> second burst AWADDR=0x00000000.

Source files
------------

// File: rtl/axi_traffic_gen.sv
// AXI3 write/read-compare traffic generator.
// Writes NUM_BURST INCR bursts of an incrementing data pattern, reads each one
// back right after its write response, and counts protocol/data errors.
// A single transaction is in flight at any time.
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where VALID and READY are both 1. VALID is never withdrawn before that edge,
// and the payload (address, data, last) is held stable while VALID=1 and READY=0.
// This block's own VALID/READY outputs are decoded from the FSM state, so they
// can only change on a state transition.
module axi_traffic_gen #(
    parameter int MST_ID    = 0,
    parameter int WIDTH_ID  = 4,
    parameter int WIDTH_AD  = 32,
    parameter int WIDTH_DA  = 32,
    parameter int NUM_BURST = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    START,
    input  logic [WIDTH_AD-1:0]     START_ADDR,
    input  logic [3:0]              BURST_LEN,
    input  logic [WIDTH_DA-1:0]     SEED,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    CFG_ERR,
    output logic [15:0]             ERR_CNT,
    // write address channel
    output logic [WIDTH_ID-1:0]     AWID,
    output logic [WIDTH_AD-1:0]     AWADDR,
    output logic [3:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    // write data channel
    output logic [WIDTH_ID-1:0]     WID,
    output logic [WIDTH_DA-1:0]     WDATA,
    output logic [WIDTH_DA/8-1:0]   WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    // write response channel
    input  logic [WIDTH_ID-1:0]     BID,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    // read address channel
    output logic [WIDTH_ID-1:0]     ARID,
    output logic [WIDTH_AD-1:0]     ARADDR,
    output logic [3:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    // read data channel
    input  logic [WIDTH_ID-1:0]     RID,
    input  logic [WIDTH_DA-1:0]     RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY,
    // current FSM state, for observation only
    output logic [2:0]              dbg_state_o
);

    localparam int                  WIDTH_DS   = WIDTH_DA / 8;
    localparam int                  SZ         = $clog2(WIDTH_DS);
    localparam logic [WIDTH_ID-1:0] ID_VAL     = WIDTH_ID'(MST_ID);
    localparam logic [15:0]         LAST_BURST = 16'(NUM_BURST - 1);
    localparam logic [WIDTH_AD-1:0] LOW_MASK   = WIDTH_AD'(WIDTH_DS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_NEXT = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH_AD-1:0]   addr_q;       // address of the current burst
    logic [3:0]            len_q;        // latched AxLEN
    logic [WIDTH_DA-1:0]   data_base_q;  // data of beat 0 of the current burst
    logic [3:0]            beat_q;       // beat index inside the current burst
    logic [15:0]           burst_q;      // burst index inside the run
    logic [15:0]           err_q;
    logic                  done_q;
    logic                  cfg_err_q;

    // configuration check on the live START inputs
    logic [4:0]            start_n;
    logic [WIDTH_AD-1:0]   start_beat;
    logic                  size_ok;
    logic                  low_ok;
    logic                  beat_mod_ok;
    logic                  cfg_ok;

    // datapath helpers
    logic [4:0]            run_n;
    logic [WIDTH_AD-1:0]   addr_step;
    logic [WIDTH_DA-1:0]   beat_data;
    logic                  beat_last;
    logic                  last_burst;
    logic                  b_err;
    logic                  r_err;

    assign start_n     = {1'b0, BURST_LEN} + 5'd1;
    assign start_beat  = START_ADDR >> SZ;
    assign size_ok     = ((32'(start_n) << SZ) <= 32'd4096);
    assign low_ok      = ((START_ADDR & LOW_MASK) == '0);
    assign cfg_ok      = size_ok && low_ok && beat_mod_ok;

    assign run_n       = {1'b0, len_q} + 5'd1;
    assign addr_step   = WIDTH_AD'(run_n) << SZ;
    assign beat_data   = data_base_q + WIDTH_DA'(beat_q);
    assign beat_last   = (beat_q == len_q);
    assign last_burst  = (burst_q == LAST_BURST);

    assign b_err = (BRESP != 2'b00) || (BID != ID_VAL);
    assign r_err = (RRESP != 2'b00) || (RID != ID_VAL) ||
                   (RDATA != beat_data) || (RLAST != beat_last);

    // Burst length in beats need not be a power of two, so alignment to
    // N*WIDTH_DS is checked as "beat address is a multiple of N"; each branch
    // divides by a constant.
    always_comb begin
        beat_mod_ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (BURST_LEN == 4'(i)) begin
                beat_mod_ok = ((start_beat % WIDTH_AD'(i + 1)) == '0);
            end
        end
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived channel controls.
    always_comb begin
        state_d = state_q;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        WLAST   = 1'b0;
        BREADY  = 1'b0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        BUSY    = 1'b1;
        case (state_q)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START && cfg_ok) state_d = S_AW;
            end
            S_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_d = S_W;
            end
            S_W: begin
                WVALID = 1'b1;
                WLAST  = beat_last;
                if (WREADY && beat_last) state_d = S_B;
            end
            S_B: begin
                BREADY = 1'b1;
                if (BVALID) state_d = S_AR;
            end
            S_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = S_R;
            end
            S_R: begin
                RREADY = 1'b1;
                // RLAST is only checked, never trusted to end the burst
                if (RVALID && beat_last) state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = last_burst ? S_IDLE : S_AW;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Run configuration, address/data generation, error counting and pulses.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q      <= '0;
            len_q       <= '0;
            data_base_q <= '0;
            beat_q      <= '0;
            burst_q     <= '0;
            err_q       <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        if (cfg_ok) begin
                            addr_q      <= START_ADDR;
                            len_q       <= BURST_LEN;
                            data_base_q <= SEED;
                            beat_q      <= '0;
                            burst_q     <= '0;
                            err_q       <= '0;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_W: begin
                    if (WREADY) beat_q <= beat_last ? 4'd0 : beat_q + 4'd1;
                end
                S_B: begin
                    if (BVALID && b_err && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
                end
                S_R: begin
                    if (RVALID) begin
                        beat_q <= beat_last ? 4'd0 : beat_q + 4'd1;
                        if (r_err && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
                    end
                end
                S_NEXT: begin
                    if (last_burst) begin
                        done_q <= 1'b1;
                    end else begin
                        addr_q      <= addr_q + addr_step;
                        data_base_q <= data_base_q + WIDTH_DA'(run_n);
                        burst_q     <= burst_q + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign DONE        = done_q;
    assign CFG_ERR     = cfg_err_q;
    assign ERR_CNT     = err_q;
    assign dbg_state_o = state_q;

    assign AWID    = ID_VAL;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = 3'(SZ);
    assign AWBURST = 2'b01;

    assign WID     = ID_VAL;
    assign WDATA   = beat_data;
    assign WSTRB   = '1;

    assign ARID    = ID_VAL;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = 3'(SZ);
    assign ARBURST = 2'b01;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Bench for axi_traffic_gen: a memory slave with optional stalls and fault
// injection, plus directed runs checked against an expected address/data queue.
module tb_axi_traffic_gen;

  localparam int MST_ID    = 5;
  localparam int WIDTH_ID  = 4;
  localparam int WIDTH_AD  = 32;
  localparam int WIDTH_DA  = 32;
  localparam int NUM_BURST = 2;

  logic                ACLK, ARESET, START;
  logic [WIDTH_AD-1:0] START_ADDR;
  logic [3:0]          BURST_LEN;
  logic [WIDTH_DA-1:0] SEED;
  logic                BUSY, DONE, CFG_ERR;
  logic [15:0]         ERR_CNT;
  logic [WIDTH_ID-1:0] AWID, WID, BID, ARID, RID;
  logic [WIDTH_AD-1:0] AWADDR, ARADDR;
  logic [3:0]          AWLEN, ARLEN, WSTRB;
  logic [2:0]          AWSIZE, ARSIZE, dbg_state;
  logic [1:0]          AWBURST, ARBURST, BRESP, RRESP;
  logic                AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic                ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [WIDTH_DA-1:0] WDATA, RDATA;

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] mem [logic [31:0]];

  // slave controls and state
  int          stall_max = 0;
  int          corrupt_beat = -1;
  bit          bresp_err_once = 0;
  int          r_beat_cnt = 0;
  int          done_cnt = 0;
  logic [3:0]  cur_bl = 4'd0;
  int          w_cnt = 0;
  int          r_left = 0;
  logic [31:0] w_addr, r_addr, last_awaddr;
  bit          b_pend, b_fired, r_fired, w_open;
  int          aw_w, w_w, ar_w, b_w, r_w;
  bit          aw_hold, w_hold, ar_hold;
  logic [31:0] aw_prev, w_prev, ar_prev;
  logic        w_last_prev;

  axi_traffic_gen #(
    .MST_ID(MST_ID), .WIDTH_ID(WIDTH_ID), .WIDTH_AD(WIDTH_AD),
    .WIDTH_DA(WIDTH_DA), .NUM_BURST(NUM_BURST)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .START(START), .START_ADDR(START_ADDR),
    .BURST_LEN(BURST_LEN), .SEED(SEED), .BUSY(BUSY), .DONE(DONE),
    .CFG_ERR(CFG_ERR), .ERR_CNT(ERR_CNT),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .dbg_state_o(dbg_state)
  );

  // clock
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ready_gen(input logic v, input int w_in, output int w_out, output logic rdy);
    w_out = w_in;
    rdy   = 1'b0;
    if (!v) begin
      w_out = -1;
    end else begin
      if (w_out < 0) w_out = int'($urandom_range(0, stall_max));
      if (w_out == 0) rdy = 1'b1;
      else w_out--;
    end
  endtask

  // Slave responder and bus monitor; acts at the falling edge.
  initial begin
    AWREADY = 0; WREADY = 0; ARREADY = 0;
    BVALID = 0; BID = '0; BRESP = '0;
    RVALID = 0; RID = '0; RRESP = '0; RDATA = '0; RLAST = 0;
    aw_w = -1; w_w = -1; ar_w = -1; b_w = -1; r_w = -1;
    b_pend = 0; b_fired = 0; r_fired = 0; w_open = 0;
    aw_hold = 0; w_hold = 0; ar_hold = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0; RLAST = 0;
        aw_w = -1; w_w = -1; ar_w = -1; b_w = -1; r_w = -1;
        b_pend = 0; b_fired = 0; r_fired = 0; w_open = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0; w_cnt = 0; r_left = 0;
      end else begin
        if (DONE) begin
          done_cnt++;
          check("done_busy_low", BUSY, 0);
        end
        // payload must hold while stalled
        if (aw_hold) begin
          check("aw_valid_held", AWVALID, 1);
          check("aw_addr_stable", AWADDR, aw_prev);
        end
        if (w_hold) begin
          check("w_valid_held", WVALID, 1);
          check("w_data_stable", WDATA, w_prev);
          check("w_last_stable", WLAST, w_last_prev);
        end
        if (ar_hold) begin
          check("ar_valid_held", ARVALID, 1);
          check("ar_addr_stable", ARADDR, ar_prev);
        end
        if (WVALID) check("w_after_aw", w_open, 1);

        if (b_fired) begin BVALID = 0; b_fired = 0; end
        if (r_fired) begin RVALID = 0; r_fired = 0; end

        ready_gen(AWVALID, aw_w, aw_w, AWREADY);
        ready_gen(WVALID, w_w, w_w, WREADY);
        ready_gen(ARVALID, ar_w, ar_w, ARREADY);

        if (b_pend && !BVALID) begin
          if (b_w < 0) b_w = int'($urandom_range(0, stall_max));
          if (b_w == 0) begin
            BVALID = 1;
            BID = WIDTH_ID'(MST_ID);
            BRESP = bresp_err_once ? 2'b10 : 2'b00;
            bresp_err_once = 0;
            b_w = -1;
          end else b_w--;
        end
        if (r_left > 0 && !RVALID) begin
          if (r_w < 0) r_w = int'($urandom_range(0, stall_max));
          if (r_w == 0) begin
            RVALID = 1;
            RID = WIDTH_ID'(MST_ID);
            RRESP = 2'b00;
            RDATA = mem[r_addr];
            if (r_beat_cnt == corrupt_beat) RDATA = RDATA ^ 32'h0000_0100;
            RLAST = (r_left == 1);
            r_w = -1;
          end else r_w--;
        end

        aw_hold = AWVALID && !AWREADY; aw_prev = AWADDR;
        w_hold  = WVALID && !WREADY;   w_prev = WDATA; w_last_prev = WLAST;
        ar_hold = ARVALID && !ARREADY; ar_prev = ARADDR;

        if (AWVALID && AWREADY) begin
          logic [31:0] ea;
          ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
          check("awaddr", AWADDR, ea);
          check("awlen", AWLEN, cur_bl);
          check("awsize", AWSIZE, 3'd2);
          check("awburst", AWBURST, 2'b01);
          check("awid", AWID, MST_ID);
          last_awaddr = ea; w_addr = AWADDR; w_cnt = 0; w_open = 1; aw_w = -1;
        end
        if (WVALID && WREADY) begin
          logic [31:0] ed;
          ed = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'hDEAD_BEEF;
          check("wdata", WDATA, ed);
          check("wlast", WLAST, (w_cnt == int'(cur_bl)));
          check("wstrb", WSTRB, 4'hF);
          check("wid", WID, MST_ID);
          mem[w_addr + 32'(w_cnt * 4)] = WDATA;
          w_cnt++;
          w_w = -1;
          if (w_cnt == int'(cur_bl) + 1) begin b_pend = 1; w_open = 0; end
        end
        if (BVALID && BREADY) begin
          b_fired = 1; b_pend = 0;
        end
        if (ARVALID && ARREADY) begin
          check("araddr", ARADDR, last_awaddr);
          check("arlen", ARLEN, cur_bl);
          check("arsize", ARSIZE, 3'd2);
          check("arburst", ARBURST, 2'b01);
          check("arid", ARID, MST_ID);
          r_addr = ARADDR; r_left = int'(cur_bl) + 1; ar_w = -1;
        end
        if (RVALID && RREADY) begin
          r_fired = 1; r_addr = r_addr + 32'd4; r_left--; r_beat_cnt++;
        end
      end
    end
  end

  task automatic push_expect(input logic [31:0] addr, input logic [3:0] bl, input logic [31:0] seed);
    logic [31:0] n;
    n = 32'(bl) + 32'd1;
    for (int b = 0; b < NUM_BURST; b++) begin
      exp_addr_q.push_back(addr + 32'(b) * n * 32'd4);
      for (int k = 0; k < int'(n); k++) exp_data_q.push_back(seed + 32'(b) * n + 32'(k));
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!DONE && cyc < 3000) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    check({tag, "_done_seen"}, DONE, 1);
    check({tag, "_done_busy"}, BUSY, 0);
    @(posedge ACLK); #1;
    check({tag, "_done_pulse"}, DONE, 0);
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] addr, input logic [3:0] bl,
                               input logic [31:0] seed, input int exp_err);
    int d0;
    d0 = done_cnt;
    push_expect(addr, bl, seed);
    cur_bl = bl; r_beat_cnt = 0;
    START_ADDR = addr; BURST_LEN = bl; SEED = seed; START = 1;
    @(posedge ACLK); #1;
    START = 0;
    check({tag, "_busy"}, BUSY, 1);
    check({tag, "_awvalid"}, AWVALID, 1);
    check({tag, "_err_clear"}, ERR_CNT, 0);
    // a START during the run must be ignored
    START_ADDR = addr + 32'h4; SEED = seed + 32'h77; START = 1;
    @(posedge ACLK); #1;
    START = 0; START_ADDR = addr; SEED = seed;
    wait_done(tag);
    check({tag, "_err_cnt"}, ERR_CNT, exp_err);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_addr_q_empty"}, exp_addr_q.size(), 0);
    check({tag, "_data_q_empty"}, exp_data_q.size(), 0);
  endtask

  task automatic reject(input string tag, input logic [31:0] addr, input logic [3:0] bl);
    START_ADDR = addr; BURST_LEN = bl; START = 1;
    @(posedge ACLK); #1;
    START = 0;
    check({tag, "_cfg_err"}, CFG_ERR, 1);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_awvalid"}, AWVALID, 0);
    check({tag, "_state"}, dbg_state, 0);
    @(posedge ACLK); #1;
    check({tag, "_cfg_err_pulse"}, CFG_ERR, 0);
    check({tag, "_busy2"}, BUSY, 0);
    check({tag, "_awvalid2"}, AWVALID, 0);
  endtask

  // directed sequence
  initial begin
    int d_rst;
    int cyc;
    ARESET = 1; START = 0; START_ADDR = '0; BURST_LEN = '0; SEED = '0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awvalid", AWVALID, 0);
    check("rst_wvalid", WVALID, 0);
    check("rst_arvalid", ARVALID, 0);
    check("rst_bready", BREADY, 0);
    check("rst_rready", RREADY, 0);
    check("rst_wlast", WLAST, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_cfg_err", CFG_ERR, 0);
    check("rst_err_cnt", ERR_CNT, 0);
    check("rst_awaddr", AWADDR, 0);
    check("rst_araddr", ARADDR, 0);
    check("rst_wdata", WDATA, 0);
    check("rst_state", dbg_state, 0);
    ARESET = 0;
    @(posedge ACLK); #1;

    // zero-wait memory
    stall_max = 0;
    run_and_check("basic", 32'h100, 4'd3, 32'hA0, 0);

    // random stalls on every channel
    stall_max = 5;
    run_and_check("stall", 32'h100, 4'd3, 32'hA0, 0);

    // one corrupted read beat and one error write response
    stall_max = 2; corrupt_beat = 5; bresp_err_once = 1;
    run_and_check("fault", 32'h100, 4'd3, 32'hA0, 2);
    corrupt_beat = -1;

    // misaligned start is rejected and the error count is left alone
    reject("misalign", 32'h104, 4'd3);
    check("err_hold_after_done", ERR_CNT, 2);
    reject("misalign3", 32'h10, 4'd2);

    // three-beat bursts at a 12-byte aligned address
    stall_max = 1;
    run_and_check("len3", 32'h18, 4'd2, $urandom, 0);

    // reset while beat 2 of the first write burst is offered
    stall_max = 0;
    push_expect(32'h200, 4'd3, 32'h55);
    cur_bl = 4'd3;
    START_ADDR = 32'h200; BURST_LEN = 4'd3; SEED = 32'h55; START = 1;
    @(posedge ACLK); #1;
    START = 0;
    cyc = 0;
    while (!(WVALID && w_cnt == 2) && cyc < 200) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    check("abort_reached_beat2", w_cnt, 2);
    d_rst = done_cnt;
    ARESET = 1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge ACLK); #1;
    check("abort_awvalid", AWVALID, 0);
    check("abort_wvalid", WVALID, 0);
    check("abort_arvalid", ARVALID, 0);
    check("abort_bready", BREADY, 0);
    check("abort_rready", RREADY, 0);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_err_cnt", ERR_CNT, 0);
    check("abort_wdata", WDATA, 0);
    ARESET = 0;
    run_and_check("after_abort", 32'h200, 4'd3, 32'h55, 0);
    check("abort_no_extra_done", done_cnt - d_rst, 1);

    // address wraps to zero on the second burst
    stall_max = 3;
    run_and_check("wrap", 32'hFFFF_FFF0, 4'd3, 32'h1234_5678, 0);

    repeat (3) @(posedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
